act_buf_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single SRAM port of the activation buffer between `numReq` requesters, such as the DMA fill engine, the array input feeder and the host debug port. It accepts valid/ready requests and issues at most one SRAM access per cycle. Requesters can hold a locked burst of up to `maxBurst` back-to-back beats. Read responses are routed back to the issuing requester one cycle after issue.

---
 rtl/act_buf_arbiter.sv | 147 ++++++++++++++
 tb/tb_act_buf_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_buf_arbiter.sv
// Round-robin arbiter giving numReq requesters the one activation-buffer SRAM port; grant and issue are combinational, read data returns one cycle after issue.
// Backpressure: only the granted requester sees ready; a locked owner blocks everyone else even while it idles; responses cannot be stalled.
module act_buf_arbiter #(
  parameter int numReq    = 3,
  parameter int addrWidth = 18,
  parameter int dataWidth = 256,
  parameter int maxBurst  = 16
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [numReq-1:0]             req_valid_i,
  output logic [numReq-1:0]             req_ready_o,
  input  logic [numReq-1:0]             req_we_i,
  input  logic [numReq-1:0]             req_lock_i,
  input  logic [numReq*addrWidth-1:0]   req_addr_i,
  input  logic [numReq*dataWidth-1:0]   req_wdata_i,
  output logic [numReq-1:0]             rsp_valid_o,
  output logic [dataWidth-1:0]          rsp_data_o,
  output logic                          mem_en_o,
  output logic                          mem_we_o,
  output logic [addrWidth-1:0]          mem_addr_o,
  output logic [dataWidth-1:0]          mem_wdata_o,
  input  logic [dataWidth-1:0]          mem_rdata_i,
  output logic                          locked_o
);

  localparam int IdW  = $clog2(numReq);
  localparam int CntW = $clog2(maxBurst) + 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]    own_id_q, own_id_d;
  logic [IdW-1:0]    rsp_id_q, rsp_id_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic              rsp_pend_q, rsp_pend_d;

  logic              gnt_vld;
  logic [IdW-1:0]    gnt_id;
  logic [IdW-1:0]    gnt_nxt;
  logic [numReq-1:0] gnt_oh;
  logic              gnt_we;
  logic              gnt_lock;
  logic [CntW-1:0]   beat_inc;
  int                scan_sum;

  // Scan from the highest offset down so the lowest offset from rr_ptr_q wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    scan_sum = 0;
    if (state_q == ST_LOCKED) begin
      gnt_vld = req_valid_i[own_id_q];
      gnt_id  = own_id_q;
    end else begin
      for (int k = numReq - 1; k >= 0; k--) begin
        scan_sum = int'(rr_ptr_q) + k;
        if (scan_sum >= numReq) begin
          scan_sum = scan_sum - numReq;
        end
        if (req_valid_i[IdW'(scan_sum)]) begin
          gnt_vld = 1'b1;
          gnt_id  = IdW'(scan_sum);
        end
      end
    end
    // Nothing is accepted while reset is held, so outputs sit at reset values.
    gnt_vld = gnt_vld & nrst;
  end

  assign gnt_oh   = gnt_vld ? (numReq'(1) << gnt_id) : '0;
  assign gnt_we   = req_we_i[gnt_id];
  assign gnt_lock = req_lock_i[gnt_id];
  assign gnt_nxt  = (gnt_id == IdW'(numReq - 1)) ? '0 : gnt_id + 1'b1;
  assign beat_inc = beat_cnt_q + 1'b1;

  assign req_ready_o = gnt_oh;
  assign mem_en_o    = gnt_vld;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    for (int i = 0; i < numReq; i++) begin
      if (gnt_oh[i]) begin
        mem_we_o    = req_we_i[i];
        mem_addr_o  = req_addr_i[i*addrWidth +: addrWidth];
        mem_wdata_o = req_wdata_i[i*dataWidth +: dataWidth];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    own_id_d   = own_id_q;
    beat_cnt_d = beat_cnt_q;
    rsp_pend_d = gnt_vld & ~gnt_we;
    rsp_id_d   = gnt_vld ? gnt_id : rsp_id_q;
    if (gnt_vld) begin
      if (state_q == ST_IDLE) begin
        if (gnt_lock) begin
          state_d    = ST_LOCKED;
          own_id_d   = gnt_id;
          beat_cnt_d = CntW'(1);
        end else begin
          rr_ptr_d = gnt_nxt;
        end
      end else begin
        beat_cnt_d = beat_inc;
        // The beat that reaches maxBurst releases even if lock is still asserted.
        if (!gnt_lock || beat_inc == CntW'(maxBurst)) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = gnt_nxt;
          beat_cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      own_id_q   <= '0;
      rsp_id_q   <= '0;
      beat_cnt_q <= '0;
      rsp_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      own_id_q   <= own_id_d;
      rsp_id_q   <= rsp_id_d;
      beat_cnt_q <= beat_cnt_d;
      rsp_pend_q <= rsp_pend_d;
    end
  end

  assign locked_o    = (state_q == ST_LOCKED);
  assign rsp_valid_o = rsp_pend_q ? (numReq'(1) << rsp_id_q) : '0;
  assign rsp_data_o  = rsp_pend_q ? mem_rdata_i : '0;

  a_ready_onehot : assert property (@(posedge clk) disable iff (!nrst) $onehot0(req_ready_o));
  a_en_matches   : assert property (@(posedge clk) disable iff (!nrst) mem_en_o == (|req_ready_o));

endmodule

// File: tb/tb_act_buf_arbiter.sv
// Randomized and directed bench for act_buf_arbiter; a spec-level model predicts each cycle's issue and every read response.
module tb_act_buf_arbiter;
  localparam int N  = 3;
  localparam int AW = 18;
  localparam int DW = 256;
  localparam int MB = 16;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic [N-1:0]      req_valid_i = '0;
  logic [N-1:0]      req_ready_o;
  logic [N-1:0]      req_we_i = '0;
  logic [N-1:0]      req_lock_i = '0;
  logic [N*AW-1:0]   req_addr_i = '0;
  logic [N*DW-1:0]   req_wdata_i = '0;
  logic [N-1:0]      rsp_valid_o;
  logic [DW-1:0]     rsp_data_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [AW-1:0]     mem_addr_o;
  logic [DW-1:0]     mem_wdata_o;
  logic [DW-1:0]     mem_rdata_i = '0;
  logic              locked_o;

  act_buf_arbiter #(.numReq(N), .addrWidth(AW), .dataWidth(DW), .maxBurst(MB)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_lock_i(req_lock_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  rdy;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          locked;
  } exp_t;

  typedef struct packed {
    logic [31:0]   id;
    logic [31:0]   due;
    logic [DW-1:0] data;
  } rsp_t;

  exp_t          exp_q[$];
  rsp_t          rsp_q[$];
  logic [DW-1:0] ref_mem[int];
  logic [DW-1:0] sram[int];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;

  // Reference arbitration state, kept as plain integers.
  int m_locked = 0;
  int m_rr = 0;
  int m_own = 0;
  int m_beat = 0;

  function automatic logic [DW-1:0] init_dat(int a);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ 32'(a);
    return {8{w}};
  endfunction

  // Behavioural SRAM: write at the edge, read data valid the following cycle.
  always @(posedge clk) begin
    if (mem_en_o && mem_we_o) begin
      sram[int'(mem_addr_o)] = mem_wdata_o;
    end
    if (mem_en_o && !mem_we_o) begin
      mem_rdata_i <= sram.exists(int'(mem_addr_o)) ? sram[int'(mem_addr_o)] : init_dat(int'(mem_addr_o));
    end else begin
      mem_rdata_i <= {8{32'($urandom)}};
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, expv);
    end
  endtask

  exp_t e_mon;
  rsp_t r_mon;

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e_mon = exp_q.pop_front();
        chk("ready", DW'(req_ready_o), DW'(e_mon.rdy));
        chk("mem_ctl", DW'({mem_en_o, mem_we_o, mem_addr_o}), DW'({e_mon.en, e_mon.we, e_mon.addr}));
        chk("mem_wdata", mem_wdata_o, e_mon.wdata);
        chk("locked", DW'(locked_o), DW'(e_mon.locked));
      end
      if (rsp_valid_o != '0) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_spurious", DW'(rsp_valid_o), '0);
        end else begin
          r_mon = rsp_q.pop_front();
          chk("rsp_cycle", DW'(cyc), DW'(r_mon.due));
          chk("rsp_id", DW'(rsp_valid_o), DW'(N'(1) << r_mon.id));
          chk("rsp_data", rsp_data_o, r_mon.data);
        end
      end else begin
        chk("rsp_idle_data", rsp_data_o, '0);
        if (rsp_q.size() > 0 && int'(rsp_q[0].due) <= cyc) begin
          r_mon = rsp_q.pop_front();
          chk("rsp_missing", DW'(rsp_valid_o), DW'(N'(1) << r_mon.id));
        end
      end
    end
  end

  // Drive one cycle and push what the spec says must happen in it.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] we, input logic [N-1:0] lk,
                      input logic [N*AW-1:0] ad, input logic [N*DW-1:0] wd, input bit rst);
    exp_t e;
    rsp_t r;
    int   g;
    @(posedge clk);
    #1;
    nrst        = !rst;
    req_valid_i = v;
    req_we_i    = we;
    req_lock_i  = lk;
    req_addr_i  = ad;
    req_wdata_i = wd;
    cyc++;
    e = '0;
    if (rst) begin
      m_locked = 0; m_rr = 0; m_own = 0; m_beat = 0;
      rsp_q.delete();
      exp_q.push_back(e);
      return;
    end
    e.locked = (m_locked != 0);
    g = -1;
    if (m_locked != 0) begin
      if (v[m_own]) g = m_own;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    if (g >= 0) begin
      e.rdy   = N'(1) << g;
      e.en    = 1'b1;
      e.we    = we[g];
      e.addr  = ad[g*AW +: AW];
      e.wdata = wd[g*DW +: DW];
      if (we[g]) begin
        ref_mem[int'(e.addr)] = e.wdata;
      end else begin
        r.id   = 32'(g);
        r.due  = 32'(cyc + 1);
        r.data = ref_mem.exists(int'(e.addr)) ? ref_mem[int'(e.addr)] : init_dat(int'(e.addr));
        rsp_q.push_back(r);
      end
      if (m_locked == 0) begin
        if (lk[g]) begin
          m_locked = 1; m_own = g; m_beat = 1;
        end else begin
          m_rr = (g + 1) % N;
        end
      end else begin
        m_beat++;
        if (!lk[g] || m_beat == MB) begin
          m_locked = 0; m_rr = (g + 1) % N;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  function automatic logic [N*AW-1:0] mk_ad(int a0, int a1, int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [N*DW-1:0] rnd_wd();
    logic [N*DW-1:0] w;
    for (int i = 0; i < N*DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [N*AW-1:0] rnd_ad();
    logic [N*AW-1:0] a;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'($urandom_range(0, 15));
    return a;
  endfunction

  task automatic idle();
    step('0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic unlock_owner();
    for (int i = 0; i < MB + 2 && m_locked != 0; i++) begin
      step(N'(1) << m_own, '0, '0, rnd_ad(), rnd_wd(), 1'b0);
    end
  endtask

  initial begin
    logic [N*DW-1:0] wd;
    // Reset held with requests pending: nothing may be accepted.
    repeat (3) step(3'b111, 3'b000, 3'b000, mk_ad(1, 2, 3), rnd_wd(), 1'b1);

    // Round robin from reset: grants 0,1,2,0.
    repeat (4) step(3'b111, 3'b000, 3'b000, mk_ad(5, 6, 7), rnd_wd(), 1'b0);

    // Read after write on requester 1.
    idle();
    wd = '0;
    wd[DW +: DW] = {32{8'hA5}};
    step(3'b010, 3'b010, 3'b000, mk_ad(0, 'h40, 0), wd, 1'b0);
    step(3'b010, 3'b000, 3'b000, mk_ad(0, 'h40, 0), '0, 1'b0);
    idle();

    // Locked burst by requester 2 with 0 and 1 waiting.
    step(3'b100, 3'b000, 3'b100, mk_ad(0, 0, 8), rnd_wd(), 1'b0);
    repeat (3) step(3'b111, 3'b000, 3'b100, mk_ad(1, 2, 9), rnd_wd(), 1'b0);
    step(3'b111, 3'b000, 3'b000, mk_ad(1, 2, 10), rnd_wd(), 1'b0);
    repeat (2) step(3'b111, 3'b000, 3'b000, mk_ad(3, 4, 11), rnd_wd(), 1'b0);
    idle();

    // Forced release: requester 0 keeps lock asserted for 20 beats.
    step(3'b001, 3'b000, 3'b001, mk_ad(2, 3, 0), rnd_wd(), 1'b0);
    repeat (19) step(3'b011, N'($urandom_range(0, 1)), 3'b001, rnd_ad(), rnd_wd(), 1'b0);
    unlock_owner();
    idle();

    // Owner bubble: requester 2 locks, then goes quiet for 3 cycles.
    step(3'b100, 3'b000, 3'b100, mk_ad(0, 0, 12), rnd_wd(), 1'b0);
    step(3'b100, 3'b100, 3'b100, mk_ad(0, 0, 12), rnd_wd(), 1'b0);
    repeat (3) step(3'b010, 3'b000, 3'b000, mk_ad(0, 5, 0), rnd_wd(), 1'b0);
    step(3'b110, 3'b000, 3'b000, mk_ad(0, 5, 12), rnd_wd(), 1'b0);
    idle();

    // Reset mid-lock with a read pending, then requester 0 first.
    step(3'b001, 3'b000, 3'b001, mk_ad(13, 0, 0), rnd_wd(), 1'b0);
    step(3'b011, 3'b000, 3'b001, mk_ad(14, 1, 0), rnd_wd(), 1'b0);
    repeat (2) step(3'b111, 3'b000, 3'b001, mk_ad(14, 1, 2), rnd_wd(), 1'b1);
    step(3'b111, 3'b000, 3'b000, mk_ad(6, 7, 8), rnd_wd(), 1'b0);

    // Random traffic with mixed bursts and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      step(N'($urandom), N'($urandom), N'($urandom), rnd_ad(), rnd_wd(),
           ($urandom_range(0, 499) == 0));
    end

    repeat (3) idle();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", DW'(rsp_q.size() + exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
